// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide sequencer owning the HI/LO pair: radix-2 shift-add
// multiply and restoring divide, one step per cycle over WIDTH cycles.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  input  logic             flush_i,
  input  logic             hilo_rd_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_DIV = 2'b01, OP_MTHI = 2'b10, OP_MTLO = 2'b11} op_t;

  state_t             state, state_nxt;
  op_t                op;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [WIDTH-1:0]   hi, lo;
  logic               dbz;

  logic               accept;
  logic               rt_zero;
  logic               start_arith;
  logic               rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op          = op_t'(op_i);
  assign accept      = (state == IDLE) && start_i && !flush_i;
  assign rt_zero     = (rt_val_i == '0);
  assign start_arith = accept && ((op == OP_MUL) || ((op == OP_DIV) && !rt_zero));

  assign rs_neg = signed_i && rs_val_i[WIDTH-1];
  assign rt_neg = signed_i && rt_val_i[WIDTH-1];
  assign rs_abs = rs_neg ? -rs_val_i : rs_val_i;
  assign rt_abs = rt_neg ? -rt_val_i : rt_val_i;

  // Multiply: acc holds {partial product, remaining multiplier bits}; shift right each step.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc holds {partial remainder, dividend bits / quotient bits}; shift left each step.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, opb});
  assign div_diff  = div_shift - {1'b0, opb};
  assign div_next  = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

  assign prod_fix = neg_res ? -acc : acc;
  assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    done_o    = 1'b0;
    case (state)
      IDLE: if (start_arith) state_nxt = RUN;
      RUN: begin
        if (flush_i)         state_nxt = IDLE;
        else if (cnt == '0)  state_nxt = FIX;
      end
      FIX: begin
        state_nxt = IDLE;
        done_o    = !flush_i;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o        = (state != IDLE);
  assign stall_o       = busy_o && (start_i || hilo_rd_i);
  assign div_by_zero_o = dbz;
  assign hi_o          = hi;
  assign lo_o          = lo;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      opb     <= '0;
      hi      <= '0;
      lo      <= '0;
      dbz     <= 1'b0;
    end else begin
      state <= state_nxt;
      dbz   <= accept && (op == OP_DIV) && rt_zero;
      if (start_arith) begin
        is_div  <= (op == OP_DIV);
        neg_res <= rs_neg ^ rt_neg;
        neg_rem <= rs_neg;
        acc     <= {{WIDTH{1'b0}}, ((op == OP_DIV) ? rs_abs : rt_abs)};
        opb     <= (op == OP_DIV) ? rt_abs : rs_abs;
        cnt     <= CW'(WIDTH - 1);
      end else if (state == RUN) begin
        acc <= is_div ? div_next : mul_next;
        cnt <= cnt - CW'(1);
      end
      if (accept && (op == OP_MTHI)) hi <= rs_val_i;
      if (accept && (op == OP_MTLO)) lo <= rs_val_i;
      if (done_o) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule
